ram_cmd_arbiter: RTL
====================

RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- ADDR_SIZE, 8: RAM address width.
- WORD_SIZE, 8: RAM data width.
- INPUT_SIZE, 10: RAM command word width, {cmd[1:0], payload[7:0]}.
- TIMEOUT, 16: maximum cycles spent waiting for read data; legal range 1..255.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- reqN_valid (N=0,1), in, 1: requester N has a transaction.
- reqN_ready, out, 1: transaction accepted this cycle.
- reqN_wr, in, 1: 1 = write, 0 = read.
- reqN_addr, in, ADDR_SIZE: target address.
- reqN_wdata, in, WORD_SIZE: write data.
- rspN_valid, out, 1: one-cycle completion pulse.
- rspN_rdata, out, WORD_SIZE: read data.
- rspN_err, out, 1: read timed out.
- ram_din, out, INPUT_SIZE: command word to RAM.
- ram_rx_valid, out, 1: command word valid.
- ram_dout, in, WORD_SIZE: RAM read data.
- ram_tx_valid, in, 1: RAM read data valid.
- busy, out, 1: state is not IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, ADDR, DATA, WAIT_RD and RESP.
REQ-005 reqN_ready SHALL be combinational: high only in IDLE, and only for the granted requester.
REQ-006 A transaction SHALL be accepted on reqN_valid && reqN_ready; wr, addr and wdata are captured at that edge and IDLE moves to ADDR.
REQ-007 Arbitration SHALL be round-robin.
- One requester valid: that requester is granted.
- Both valid: the requester not served last is granted.
- The last-served register resets to 1, so req0 wins the first tie.
REQ-008 ADDR SHALL last one cycle, driving ram_rx_valid=1 and ram_din={2'b00,addr} for a write or {2'b10,addr} for a read.
REQ-009 DATA SHALL last one cycle, driving ram_rx_valid=1 and ram_din={2'b01,wdata} for a write or {2'b11,8'h00} for a read.
- A write then goes to RESP; a read goes to WAIT_RD.
REQ-010 ram_din SHALL be 0 whenever ram_rx_valid is 0.
REQ-011 In WAIT_RD, the first cycle with ram_tx_valid=1 SHALL capture ram_dout into rdata and move to RESP.
- ram_tx_valid outside WAIT_RD is ignored.
REQ-012 WAIT_RD SHALL time out when ram_tx_valid is absent for TIMEOUT consecutive WAIT_RD cycles: move to RESP with err=1 and rdata=0.
- ram_tx_valid in the TIMEOUT-th cycle counts as success.
REQ-013 RESP SHALL last one cycle, pulsing rspN_valid for the served requester only, then return to IDLE.
- rspN_rdata and rspN_err are valid while rspN_valid=1 and are 0 otherwise.
- A write response is rdata=0, err=0.
REQ-014 Latency with acceptance in cycle T SHALL be:
- Write: ADDR at T+1, DATA at T+2, rsp_valid at T+3.
- Read with tx_valid in the k-th WAIT_RD cycle: rsp_valid at T+3+k.
REQ-015 A new acceptance SHALL be possible in the cycle after RESP, i.e. back-to-back writes every 4 cycles.
REQ-016 All outputs except reqN_ready and busy SHALL be registered.

Reset
REQ-017 While rst=1, the block SHALL immediately force:
- state IDLE;
- all outputs 0;
- the timeout counter cleared;
- the last-served register set to 1.
REQ-018 Reset mid-operation SHALL discard the in-flight transaction with no rsp pulse; arbitration restarts in the first cycle after rst deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset: assert rst mid-cycle -> all outputs 0 and busy=0 immediately.
- Write: req0 wr, addr 0x01, wdata 0x0A -> ram_din 0x001 then 0x10A on consecutive cycles with ram_rx_valid=1; rsp0_valid at T+3 with err=0.
- Read: req1 read 0x01; RAM model returns 0x0A with tx_valid in the first WAIT_RD cycle -> ram_din 0x201 then 0x300; rsp1_valid at T+4 with rdata=0x0A, err=0.
- Contention: both valid continuously after reset -> grants req0, req1, req0, req1; no rsp pulse on the wrong port.
- Timeout: read with ram_tx_valid held 0 -> rsp_valid after exactly TIMEOUT WAIT_RD cycles with err=1, rdata=0x00.
- Abort: rst pulse during WAIT_RD, then a late ram_tx_valid -> no response; the next request completes normally.

Source files
------------

// File: rtl/ram_cmd_arbiter.sv
// Two-port round-robin arbiter that serialises read/write transactions into
// the two-word command protocol of a simple RAM and returns one-cycle responses.
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int WORD_SIZE  = 8,
  parameter int INPUT_SIZE = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wr,
  input  logic [ADDR_SIZE-1:0]  req0_addr,
  input  logic [WORD_SIZE-1:0]  req0_wdata,
  output logic                  rsp0_valid,
  output logic [WORD_SIZE-1:0]  rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wr,
  input  logic [ADDR_SIZE-1:0]  req1_addr,
  input  logic [WORD_SIZE-1:0]  req1_wdata,
  output logic                  rsp1_valid,
  output logic [WORD_SIZE-1:0]  rsp1_rdata,
  output logic                  rsp1_err,
  output logic [INPUT_SIZE-1:0] ram_din,
  output logic                  ram_rx_valid,
  input  logic [WORD_SIZE-1:0]  ram_dout,
  input  logic                  ram_tx_valid,
  output logic                  busy
);

  // Handshake: a request transfers on the rising edge where valid && ready;
  // ready is only offered in IDLE, to the single granted requester.
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WAIT_RD, RESP} state_e;

  state_e                 state_q;
  logic                   last_q;
  logic                   owner_q;
  logic                   wr_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [7:0]             cnt_q;
  logic [INPUT_SIZE-1:0]  ram_din_q;
  logic                   ram_rx_valid_q;
  logic                   rsp0_valid_q, rsp1_valid_q;
  logic [WORD_SIZE-1:0]   rsp0_rdata_q, rsp1_rdata_q;
  logic                   rsp0_err_q, rsp1_err_q;

  logic grant0, grant1, accept0, accept1, sel;

  // Round robin: on a tie the requester not served last wins.
  assign grant0  = req0_valid && (!req1_valid || last_q);
  assign grant1  = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = !rst && (state_q == IDLE) && grant0;
  assign req1_ready = !rst && (state_q == IDLE) && grant1;
  assign accept0 = req0_valid && req0_ready;
  assign accept1 = req1_valid && req1_ready;
  assign sel     = accept1;

  assign busy         = !rst && (state_q != IDLE);
  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_rdata   = rsp0_rdata_q;
  assign rsp0_err     = rsp0_err_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_rdata   = rsp1_rdata_q;
  assign rsp1_err     = rsp1_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      owner_q        <= 1'b0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cnt_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp0_rdata_q   <= '0;
      rsp1_rdata_q   <= '0;
      rsp0_err_q     <= 1'b0;
      rsp1_err_q     <= 1'b0;
    end else begin
      // Command and response outputs are single-cycle unless re-asserted below.
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      rsp0_valid_q   <= 1'b0;
      rsp1_valid_q   <= 1'b0;
      rsp0_rdata_q   <= '0;
      rsp1_rdata_q   <= '0;
      rsp0_err_q     <= 1'b0;
      rsp1_err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept0 || accept1) begin
            owner_q        <= sel;
            last_q         <= sel;
            wr_q           <= sel ? req1_wr : req0_wr;
            addr_q         <= sel ? req1_addr : req0_addr;
            wdata_q        <= sel ? req1_wdata : req0_wdata;
            cnt_q          <= '0;
            ram_rx_valid_q <= 1'b1;
            ram_din_q      <= {((sel ? req1_wr : req0_wr) ? 2'b00 : 2'b10),
                               (sel ? req1_addr : req0_addr)};
            state_q        <= ADDR;
          end
        end
        ADDR: begin
          ram_rx_valid_q <= 1'b1;
          ram_din_q      <= wr_q ? {2'b01, wdata_q} : {2'b11, {WORD_SIZE{1'b0}}};
          state_q        <= DATA;
        end
        DATA: begin
          if (wr_q) begin
            rsp0_valid_q <= !owner_q;
            rsp1_valid_q <= owner_q;
            state_q      <= RESP;
          end else begin
            cnt_q   <= '0;
            state_q <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (ram_tx_valid) begin
            rsp0_valid_q <= !owner_q;
            rsp1_valid_q <= owner_q;
            if (owner_q) rsp1_rdata_q <= ram_dout;
            else         rsp0_rdata_q <= ram_dout;
            state_q      <= RESP;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            rsp0_valid_q <= !owner_q;
            rsp1_valid_q <= owner_q;
            rsp0_err_q   <= !owner_q;
            rsp1_err_q   <= owner_q;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
